expr_eval: RTL and testbench

EXPR_EVAL -- requirements
Module: expr_eval

---
 rtl/expr_eval.sv | 101 ++++++++++
 tb/tb_expr_eval.sv | 139 +++++++++++++
 2 files changed

// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for digit(('+'|'*')digit)*'=' with '*' binding tighter than '+'.
// Reports a registered result/ovf with a done pulse, or an error pulse for malformed input.
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             error,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, OPND, OPER, ERR} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d, term_q, term_d, result_q, result_d;
    logic             pend_mul_q, pend_mul_d, ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;
    logic             done_q, done_d, error_q, error_d;
    logic             is_dig, is_op, is_mul, is_eq, mul_now;
    logic [WIDTH-1:0] dig;
    logic [WIDTH+3:0] prod;
    logic [WIDTH:0]   add;

    assign is_dig  = in >= 8'h30 && in <= 8'h39;
    assign is_mul  = in == 8'h2a;
    assign is_op   = is_mul || in == 8'h2b;
    assign is_eq   = in == 8'h3d;
    assign dig     = WIDTH'(in[3:0]);
    assign prod    = {4'b0, term_q} * {{WIDTH{1'b0}}, in[3:0]};
    assign add     = {1'b0, sum_q} + {1'b0, term_q};
    assign mul_now = state_q == OPER && pend_mul_q;

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        term_d     = term_q;
        pend_mul_d = pend_mul_q;
        ovf_acc_d  = ovf_acc_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        if (in_valid) begin
            if (is_eq) begin
                done_d     = state_q == OPND;
                error_d    = state_q != OPND;
                result_d   = done_d ? add[WIDTH-1:0] : result_q;
                ovf_d      = done_d ? (ovf_acc_q | add[WIDTH]) : ovf_q;
                state_d    = IDLE;
                sum_d      = '0;
                term_d     = '0;
                pend_mul_d = 1'b0;
                ovf_acc_d  = 1'b0;
            end else if (state_q != ERR) begin
                // anything not matched below is a syntax error; stay silent until '='
                state_d = ERR;
                if (is_dig && state_q != OPND) begin
                    state_d   = OPND;
                    term_d    = mul_now ? prod[WIDTH-1:0] : dig;
                    ovf_acc_d = ovf_acc_q | (mul_now && |prod[WIDTH+3:WIDTH]);
                end else if (is_op && state_q == OPND) begin
                    state_d    = OPER;
                    pend_mul_d = is_mul;
                    sum_d      = is_mul ? sum_q : add[WIDTH-1:0];
                    ovf_acc_d  = ovf_acc_q | (!is_mul && add[WIDTH]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            term_q     <= '0;
            pend_mul_q <= 1'b0;
            ovf_acc_q  <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            term_q     <= term_d;
            pend_mul_q <= pend_mul_d;
            ovf_acc_q  <= ovf_acc_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;
    assign done   = done_q;
    assign error  = error_q;
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed self-checking bench for expr_eval (WIDTH=16).
// Inputs change on the falling edge; outputs are checked on the falling edge after the sampling edge.
module tb_expr_eval;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  in = 8'h00;
    logic        in_valid = 1'b0;
    logic [15:0] result;
    logic        done, error, ovf;
    int          n_checks = 0;
    int          n_fail = 0;

    expr_eval #(.WIDTH(16)) dut (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .result(result), .done(done), .error(error), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // every character but the last must leave done/error low
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            in = s[i];
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (i < s.len() - 1) begin
                chk({s, " mid done"}, done, 0);
                chk({s, " mid error"}, error, 0);
            end
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("gap done", done, 0);
            chk("gap error", error, 0);
        end
    endtask

    task automatic expect_done(input string tag, input logic [15:0] r, input logic o);
        chk({tag, " done"}, done, 1);
        chk({tag, " error"}, error, 0);
        chk({tag, " result"}, result, r);
        chk({tag, " ovf"}, ovf, o);
        gap(1);
    endtask

    task automatic expect_err(input string tag, input logic [15:0] r, input logic o);
        chk({tag, " error"}, error, 1);
        chk({tag, " done"}, done, 0);
        chk({tag, " result held"}, result, r);
        chk({tag, " ovf held"}, ovf, o);
        gap(1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset result", result, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);
        chk("reset ovf", ovf, 0);
        clr = 1'b0;
        @(negedge clk);

        send("1+2*3=");
        expect_done("1+2*3", 7, 0);
        send("9*9*9*9*9=");
        expect_done("9^5", 59049, 0);
        send("9*9*9*9*9*9=");
        expect_done("9^6", 7153, 1);
        send("1+=");
        expect_err("1+=", 7153, 1);
        send("a3+4=");
        expect_err("a3+4=", 7153, 1);
        send("5=");
        expect_done("5=", 5, 0);

        send("2*");
        clr = 1'b1;
        @(negedge clk);
        chk("clr done", done, 0);
        chk("clr error", error, 0);
        chk("clr result", result, 0);
        clr = 1'b0;
        @(negedge clk);
        send("4=");
        expect_done("after clr 4=", 4, 0);

        send("8");
        gap(3);
        send("*");
        gap(1);
        send("7=");
        expect_done("8*7 gaps", 56, 0);

        send("12=");
        expect_err("12=", 56, 0);
        send("0=");
        expect_done("0=", 0, 0);

        // 59049 + 6561 = 65610 wraps to 74 with carry out of the sum
        send("9*9*9*9*9+9*9*9*9=");
        expect_done("sum ovf", 74, 1);
        send("3*4+2*5+1=");
        expect_done("mixed", 23, 0);

        // a character coincident with clr is discarded, so a lone '=' is an error
        in = "5";
        in_valid = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        send("=");
        expect_err("clr drops char", 0, 0);
        send("7*+");
        gap(2);
        send("=");
        expect_err("op after op", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
